// File: rtl/present_sbox_layer_serial_pkg.sv
// Shared PRESENT constants: forward/inverse 4-bit S-box tables, nibble count and
// the S-box layer FSM state type.
package present_pkg;

    localparam int NIBBLES = 16;

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sbl_state_t;

endpackage

// File: rtl/present_sbox_layer_serial_if.sv
// Valid/ready bus between the upstream stage, the serial S-box layer and the
// downstream permutation layer. The S-box layer is the slave.
interface present_sbox_layer_serial_if;

    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/present_sbox_layer_serial_sbox4.sv
// Combinational 4-bit PRESENT S-box. With PRESENT_INV_SBOX_EN defined an i_inv
// input selects the inverse table.
module present_sbox4
    import present_pkg::*;
(
    input  logic [3:0] i_nib,
`ifdef PRESENT_INV_SBOX_EN
    input  logic       i_inv,
`endif
    output logic [3:0] o_nib
);

`ifdef PRESENT_INV_SBOX_EN
    assign o_nib = i_inv ? SBOX_INV[i_nib] : SBOX[i_nib];
`else
    assign o_nib = SBOX[i_nib];
`endif

endmodule

// File: rtl/present_sbox_layer_serial.sv
// Iterative PRESENT S-box layer: substitutes NPC nibbles of the 64-bit state per cycle.
// Optional macro PRESENT_INV_SBOX_EN adds an inv port selecting the inverse S-box.
module present_sbox_layer_serial
    import present_pkg::*;
#(
    parameter int NPC = 4
)(
    input  logic                        Clock,
    input  logic                        Reset_n,
`ifdef PRESENT_INV_SBOX_EN
    input  logic                        inv,
`endif
    present_sbox_layer_serial_if.slave  bus,
    output logic                        busy
);

    localparam int GROUPS = NIBBLES / NPC;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    sbl_state_t    r_state;
    sbl_state_t    w_next_state;
    logic [GW-1:0] r_grp;
    logic [63:0]   r_work;
    logic [63:0]   w_work_sub;
    logic          w_last;
    logic          w_accept;
    logic [3:0]    w_nib_in  [NPC];
    logic [3:0]    w_nib_out [NPC];
`ifdef PRESENT_INV_SBOX_EN
    logic          r_inv;
`endif

    assign w_last   = (r_grp == GW'(GROUPS - 1));
    assign w_accept = (r_state == IDLE) && bus.in_valid;

    // One S-box per nibble slot; the slot window slides across the state with r_grp.
    for (genvar g = 0; g < NPC; g++) begin : g_sbox
        assign w_nib_in[g] = r_work[(int'(r_grp) * NPC + g) * 4 +: 4];

        present_sbox4 u_sbox (
            .i_nib (w_nib_in[g]),
`ifdef PRESENT_INV_SBOX_EN
            .i_inv (r_inv),
`endif
            .o_nib (w_nib_out[g])
        );
    end

    always_comb begin
        w_work_sub = r_work;
        for (int g = 0; g < NPC; g++) begin
            w_work_sub[(int'(r_grp) * NPC + g) * 4 +: 4] = w_nib_out[g];
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        unique case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Working state and group counter; the counter wraps on the final group.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_work <= '0;
            r_grp  <= '0;
        end else if (w_accept) begin
            r_work <= bus.in_data;
            r_grp  <= '0;
        end else if (r_state == BUSY) begin
            r_work <= w_work_sub;
            r_grp  <= w_last ? '0 : r_grp + GW'(1);
        end
    end

`ifdef PRESENT_INV_SBOX_EN
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_inv <= 1'b0;
        end else if (w_accept) begin
            r_inv <= inv;
        end
    end
`endif

    assign bus.out_data = r_work;

endmodule

// File: tb/tb_present_sbox_layer_serial.sv
// Self-checking bench for present_sbox_layer_serial: three instances (NPC = 1, 4, 16)
// driven from vector tables, random states and multi-cycle corner-case sequences.
module tb_present_sbox_layer_serial;

    localparam int NDUT = 3;

    localparam logic [3:0] S_REF [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };
    localparam logic [3:0] S_INV_REF [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef struct {
        int          dutIdx;
        logic [63:0] din;
        logic [63:0] dout;
        int          lat;
    } vector_t;

    logic              Clock = 1'b0;
    logic              Reset_n;
    logic [NDUT-1:0]   inValid;
    logic [NDUT-1:0]   inReady;
    logic [NDUT-1:0]   outValid;
    logic [NDUT-1:0]   outReady;
    logic [NDUT-1:0]   busyS;
    logic [63:0]       inData  [NDUT];
    logic [63:0]       outData [NDUT];
`ifdef PRESENT_INV_SBOX_EN
    logic [NDUT-1:0]   invSel;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        localparam int NPC_K = (k == 0) ? 1 : (k == 1) ? 4 : 16;

        present_sbox_layer_serial_if bus ();

        assign bus.in_valid  = inValid[k];
        assign bus.in_data   = inData[k];
        assign bus.out_ready = outReady[k];
        assign inReady[k]    = bus.in_ready;
        assign outValid[k]   = bus.out_valid;
        assign outData[k]    = bus.out_data;

        present_sbox_layer_serial #(.NPC(NPC_K)) dut (
            .Clock   (Clock),
            .Reset_n (Reset_n),
`ifdef PRESENT_INV_SBOX_EN
            .inv     (invSel[k]),
`endif
            .bus     (bus.slave),
            .busy    (busyS[k])
        );
    end

    function automatic int npcOf(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    // Reference: every nibble independently through the table, no notion of cycles.
    function automatic logic [63:0] refSub(input logic [63:0] x, input bit useInv);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = useInv ? S_INV_REF[x[4*i +: 4]] : S_REF[x[4*i +: 4]];
        end
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Single transaction with out_ready held high; returns result and accept-to-valid latency.
    task automatic applyStimulus(input int k, input logic [63:0] din,
                                 output logic [63:0] dout, output int lat);
        int n;
        inData[k]   = din;
        inValid[k]  = 1'b1;
        outReady[k] = 1'b1;
        n = 0;
        while (!inReady[k] && n < 50) begin
            tick();
            n++;
        end
        tick();
        inValid[k] = 1'b0;
        lat = 0;
        while (!outValid[k] && lat < 50) begin
            tick();
            lat++;
        end
        dout = outData[k];
        tick();
    endtask

    task automatic backToBack(input int k);
        logic [63:0] q [3];
        int acc, got, lastAcc, cyc;
        bit acceptNow;
        for (int i = 0; i < 3; i++) q[i] = rand64();
        acc = 0; got = 0; lastAcc = -1; cyc = 0;
        inData[k]   = q[0];
        inValid[k]  = 1'b1;
        outReady[k] = 1'b1;
        while (got < 3 && cyc < 200) begin
            @(negedge Clock);
            acceptNow = inValid[k] && inReady[k];
            if (outValid[k]) begin
                checkOutput($sformatf("b2b data dut%0d #%0d", k, got), outData[k], refSub(q[got], 1'b0));
                got++;
            end
            @(posedge Clock);
            #1;
            cyc++;
            if (acceptNow) begin
                if (lastAcc >= 0) begin
                    checkOutput($sformatf("b2b spacing dut%0d", k), 64'(cyc - lastAcc), 64'(16 / npcOf(k) + 2));
                end
                lastAcc = cyc;
                acc++;
                if (acc < 3) inData[k] = q[acc];
                else         inValid[k] = 1'b0;
            end
        end
        if (got < 3) checkOutput($sformatf("b2b timeout dut%0d", k), 64'(got), 64'd3);
        inValid[k] = 1'b0;
        tick();
    endtask

    initial begin
        vector_t     vectors [7];
        logic [63:0] dout, a, b, held;
        int          lat, k;

        vectors[0] = '{1, 64'h0000000000000000, 64'hCCCCCCCCCCCCCCCC, 4};
        vectors[1] = '{0, 64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 16};
        vectors[2] = '{1, 64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 4};
        vectors[3] = '{2, 64'h0123456789ABCDEF, 64'hC56B90AD3EF84712, 1};
        vectors[4] = '{2, 64'hFFFFFFFFFFFFFFFF, 64'h2222222222222222, 1};
        vectors[5] = '{0, 64'hFEDCBA9876543210, 64'h21748FE3DA09B65C, 16};
        vectors[6] = '{1, 64'hFFFFFFFF00000000, 64'h22222222CCCCCCCC, 4};

        Reset_n  = 1'b0;
        inValid  = '0;
        outReady = '0;
        for (int i = 0; i < NDUT; i++) inData[i] = '0;
`ifdef PRESENT_INV_SBOX_EN
        invSel = '0;
`endif
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("reset in_ready dut%0d", i),  64'(inReady[i]),  64'd1);
            checkOutput($sformatf("reset out_valid dut%0d", i), 64'(outValid[i]), 64'd0);
            checkOutput($sformatf("reset busy dut%0d", i),      64'(busyS[i]),    64'd0);
            checkOutput($sformatf("reset out_data dut%0d", i),  outData[i],       64'd0);
        end
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            k = vectors[i].dutIdx;
            applyStimulus(k, vectors[i].din, dout, lat);
            checkOutput($sformatf("vec%0d data", i), dout, vectors[i].dout);
            checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vectors[i].lat));
            checkOutput($sformatf("vec%0d back to idle", i), 64'({outValid[k], inReady[k]}), 64'b01);
        end

        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, NDUT - 1));
            a = rand64();
            applyStimulus(k, a, dout, lat);
            checkOutput($sformatf("rand%0d data dut%0d", i, k), dout, refSub(a, 1'b0));
            checkOutput($sformatf("rand%0d latency dut%0d", i, k), 64'(lat), 64'(16 / npcOf(k)));
        end

        // Reset while NPC=4 instance is mid-substitution.
        inData[1]   = 64'h0123456789ABCDEF;
        inValid[1]  = 1'b1;
        outReady[1] = 1'b1;
        tick();
        inValid[1] = 1'b0;
        tick();
        checkOutput("pre-reset busy", 64'(busyS[1]), 64'd1);
        Reset_n = 1'b0;
        @(negedge Clock);
        checkOutput("mid reset in_ready",  64'(inReady[1]),  64'd1);
        checkOutput("mid reset out_valid", 64'(outValid[1]), 64'd0);
        checkOutput("mid reset busy",      64'(busyS[1]),    64'd0);
        @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        tick();
        a = 64'h0F1E2D3C4B5A6978;
        applyStimulus(1, a, dout, lat);
        checkOutput("post reset data", dout, refSub(a, 1'b0));
        checkOutput("post reset latency", 64'(lat), 64'd4);

        // Backpressure: result held for 10 cycles, second state waits upstream.
        a = rand64();
        b = rand64();
        inData[1]   = a;
        inValid[1]  = 1'b1;
        outReady[1] = 1'b0;
        tick();
        inData[1] = b;
        lat = 0;
        while (!outValid[1] && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput("bp latency", 64'(lat), 64'd4);
        held = refSub(a, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge Clock);
            checkOutput($sformatf("bp out_valid c%0d", c), 64'(outValid[1]), 64'd1);
            checkOutput($sformatf("bp out_data c%0d", c),  outData[1],        held);
            checkOutput($sformatf("bp in_ready c%0d", c),  64'(inReady[1]),   64'd0);
        end
        outReady[1] = 1'b1;
        tick();
        checkOutput("bp release out_valid", 64'(outValid[1]), 64'd0);
        checkOutput("bp release in_ready",  64'(inReady[1]),  64'd1);
        tick();
        inValid[1] = 1'b0;
        lat = 0;
        while (!outValid[1] && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput("bp second data", outData[1], refSub(b, 1'b0));
        checkOutput("bp second latency", 64'(lat), 64'd4);
        tick();

        for (int i = 0; i < NDUT; i++) backToBack(i);

`ifdef PRESENT_INV_SBOX_EN
        invSel[1] = 1'b1;
        applyStimulus(1, 64'hC56B90AD3EF84712, dout, lat);
        invSel[1] = 1'b0;
        checkOutput("inv known vector", dout, 64'h0123456789ABCDEF);
        checkOutput("inv latency", 64'(lat), 64'd4);
        for (int i = 0; i < 6; i++) begin
            k = int'($urandom_range(0, NDUT - 1));
            a = rand64();
            invSel[k] = 1'b0;
            applyStimulus(k, a, b, lat);
            invSel[k] = 1'b1;
            applyStimulus(k, b, dout, lat);
            invSel[k] = 1'b0;
            checkOutput($sformatf("roundtrip%0d fwd dut%0d", i, k), b, refSub(a, 1'b0));
            checkOutput($sformatf("roundtrip%0d back dut%0d", i, k), dout, a);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
